pkt_receiver: RTL and testbench
===============================

PKT_RECEIVER -- requirements
Module: pkt_receiver

Interface
REQ-001 Parameter PORT_ID, default 2'd0, destination address this receiver serves.
REQ-002 Parameter WAIT_LIMIT, default 29, maximum stall cycles with vld_in high and re low before abort.
REQ-003 Port clk, input, 1, single clock; all logic on rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port vld_in, input, 1, router output FIFO non-empty (vld_out_x).
REQ-006 Port data_in, input, 8, router output FIFO data, valid the cycle after re.
REQ-007 Port sink_ready, input, 1, downstream consumer can accept a byte this cycle.
REQ-008 Port re, output, 1, read enable to router output FIFO.
REQ-009 Port pkt_start, output, 1, one-cycle pulse when the header byte is captured.
REQ-010 Port pkt_len, output, 6, payload length from header[7:2].
REQ-011 Port pkt_addr_err, output, 1, header[1:0] != PORT_ID; valid with pkt_start.
REQ-012 Port pkt_data / pkt_data_valid, output, 8 / 1, payload byte and its one-cycle qualifier.
REQ-013 Port pkt_end / pkt_err, output, 1 / 1, end pulse and parity-mismatch flag valid with pkt_end.
REQ-014 Port abort, output, 1, one-cycle pulse on stall timeout.
REQ-015 Ports pkt_count (16) and err_count (8), outputs, good-packet and bad-packet counters.
REQ-016 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 Packet format: header {len[5:0], addr[1:0]}, len payload bytes (0..63), parity byte = XOR of header and all payload bytes.
REQ-018 Read latency: the byte is sampled from data_in exactly one cycle after a cycle with re=1.
REQ-019 States: IDLE, HDR, PAYLOAD, FLUSH.
REQ-020 IDLE: re = vld_in & sink_ready; when re=1, go to HDR.
REQ-021 HDR: re=0; capture header, pulse pkt_start, register pkt_len and pkt_addr_err, init running parity to header, set remaining = len+1, go to PAYLOAD.
REQ-022 PAYLOAD: re = vld_in & sink_ready & (reads_issued < remaining); reads may be back-to-back (one byte per cycle).
REQ-023 Each captured byte other than the last: pkt_data=byte, pkt_data_valid=1, parity ^= byte.
REQ-024 The last captured byte (parity): no pkt_data_valid; pkt_end=1, pkt_err = (byte != running parity), then IDLE.
REQ-025 Receiving continues when pkt_addr_err=1; the packet is counted as bad.
REQ-026 At pkt_end: if pkt_err|pkt_addr_err, err_count+1, else pkt_count+1; both saturate (0xFFFF, 0xFF).
REQ-027 Stall counter: increments when vld_in=1 & re=0 in IDLE or PAYLOAD; clears when re=1 or vld_in=0.
REQ-028 Stall counter reaching WAIT_LIMIT: pulse abort, err_count+1 (saturating), go to FLUSH; no pkt_end.
REQ-029 FLUSH: re=0; return to IDLE on the first cycle with vld_in=0.
REQ-030 vld_in low mid-PAYLOAD: hold state, re=0, stall counter cleared.
REQ-031 len=0: PAYLOAD issues one read (parity); pkt_end with no pkt_data_valid pulses.
REQ-032 sink_ready low suppresses new reads only; a byte already read is still presented the next cycle.

Reset
REQ-033 rst=0 asynchronously forces IDLE; re, pkt_start, pkt_data_valid, pkt_end, pkt_err, abort, busy, pkt_addr_err = 0; pkt_data, pkt_len, counters, stall counter, parity = 0.
REQ-034 Reset mid-packet discards the partial packet; after release the block waits in IDLE for vld_in.

Verification
REQ-035 PORT_ID=0; bytes 0x0C,0x11,0x22,0x33,0x0C streamed, sink_ready=1 -> pkt_start, pkt_len=3, three pkt_data_valid (0x11,0x22,0x33), pkt_end with pkt_err=0, pkt_count=1.
REQ-036 Same packet with parity 0x0D -> pkt_end with pkt_err=1, err_count=1, pkt_count unchanged.
REQ-037 Header 0x01 (len 0, addr 1), parity 0x01, PORT_ID=0 -> pkt_addr_err=1, no pkt_data_valid, pkt_end with pkt_err=0, err_count=1.
REQ-038 vld_in held high, sink_ready low for 29 cycles in PAYLOAD -> abort pulse on cycle 29, FLUSH until vld_in=0, then IDLE.
REQ-039 sink_ready toggled 1/0 each cycle during a 4-byte payload -> re never high while sink_ready=0; payload order and parity intact.
REQ-040 rst asserted after second payload byte -> all outputs 0 immediately; next full packet received correctly.

Source files
------------

// File: rtl/pkt_receiver.sv
// Receives framed packets from a router output FIFO: header, payload bytes, then a parity byte.
// Latency: each byte appears on the outputs two cycles after the cycle in which it was read (re=1).
// Backpressure: no new reads while sink_ready is low; a byte already read is still presented; a long stall aborts the packet.
module pkt_receiver #(
  parameter logic [1:0]  PORT_ID    = 2'd0,
  parameter int unsigned WAIT_LIMIT = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_in,
  input  logic [7:0]  data_in,
  input  logic        sink_ready,
  output logic        re,
  output logic        pkt_start,
  output logic [5:0]  pkt_len,
  output logic        pkt_addr_err,
  output logic [7:0]  pkt_data,
  output logic        pkt_data_valid,
  output logic        pkt_end,
  output logic        pkt_err,
  output logic        abort,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int STALL_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic                 rd_pend_q, rd_pend_d;     // a read was issued last cycle, byte is on data_in now
  logic [6:0]           rd_cnt_q, rd_cnt_d;       // reads issued in this packet after the header
  logic [6:0]           rx_cnt_q, rx_cnt_d;       // bytes captured in this packet after the header
  logic [6:0]           rem_q, rem_d;             // len + 1 (payload plus parity byte)
  logic [7:0]           parity_q, parity_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 pkt_start_q, pkt_start_d;
  logic [5:0]           pkt_len_q, pkt_len_d;
  logic                 pkt_addr_err_q, pkt_addr_err_d;
  logic [7:0]           pkt_data_q, pkt_data_d;
  logic                 pkt_data_valid_q, pkt_data_valid_d;
  logic                 pkt_end_q, pkt_end_d;
  logic                 pkt_err_q, pkt_err_d;
  logic                 abort_q, abort_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 re_c;
  logic                 end_now;

  // Next-state, read enable, capture, parity, stall and counter logic
  always_comb begin
    state_d          = state_q;
    rd_cnt_d         = rd_cnt_q;
    rx_cnt_d         = rx_cnt_q;
    rem_d            = rem_q;
    parity_d         = parity_q;
    stall_d          = '0;
    pkt_start_d      = 1'b0;
    pkt_len_d        = pkt_len_q;
    pkt_addr_err_d   = pkt_addr_err_q;
    pkt_data_d       = pkt_data_q;
    pkt_data_valid_d = 1'b0;
    pkt_end_d        = 1'b0;
    pkt_err_d        = 1'b0;
    abort_d          = 1'b0;
    pkt_count_d      = pkt_count_q;
    err_count_d      = err_count_q;
    re_c             = 1'b0;
    end_now          = 1'b0;

    case (state_q)
      S_IDLE: begin
        re_c = vld_in & sink_ready;
        if (re_c) state_d = S_HDR;
      end
      S_HDR: begin
        pkt_start_d    = 1'b1;
        pkt_len_d      = data_in[7:2];
        pkt_addr_err_d = (data_in[1:0] != PORT_ID);
        parity_d       = data_in;
        rem_d          = {1'b0, data_in[7:2]} + 7'd1;
        rd_cnt_d       = '0;
        rx_cnt_d       = '0;
        state_d        = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        re_c = vld_in & sink_ready & (rd_cnt_q < rem_q);
        if (re_c) rd_cnt_d = rd_cnt_q + 7'd1;
        if (rd_pend_q) begin
          if (rx_cnt_q + 7'd1 == rem_q) begin
            // Parity byte closes the packet
            end_now   = 1'b1;
            pkt_end_d = 1'b1;
            pkt_err_d = (data_in != parity_q);
            if ((data_in != parity_q) || pkt_addr_err_q) begin
              if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else begin
              if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
            end
            state_d = S_IDLE;
          end else begin
            pkt_data_d       = data_in;
            pkt_data_valid_d = 1'b1;
            parity_d         = parity_q ^ data_in;
            rx_cnt_d         = rx_cnt_q + 7'd1;
          end
        end
      end
      S_FLUSH: begin
        if (!vld_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Stall timeout only while waiting to read; completing a packet takes priority
    if ((state_q == S_IDLE || state_q == S_PAYLOAD) && vld_in && !re_c) begin
      if (stall_q == STALL_LAST && !end_now) begin
        abort_d = 1'b1;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        state_d = S_FLUSH;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end

    rd_pend_d = re_c;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      rd_pend_q        <= 1'b0;
      rd_cnt_q         <= '0;
      rx_cnt_q         <= '0;
      rem_q            <= '0;
      parity_q         <= '0;
      stall_q          <= '0;
      pkt_start_q      <= 1'b0;
      pkt_len_q        <= '0;
      pkt_addr_err_q   <= 1'b0;
      pkt_data_q       <= '0;
      pkt_data_valid_q <= 1'b0;
      pkt_end_q        <= 1'b0;
      pkt_err_q        <= 1'b0;
      abort_q          <= 1'b0;
      pkt_count_q      <= '0;
      err_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      rd_pend_q        <= rd_pend_d;
      rd_cnt_q         <= rd_cnt_d;
      rx_cnt_q         <= rx_cnt_d;
      rem_q            <= rem_d;
      parity_q         <= parity_d;
      stall_q          <= stall_d;
      pkt_start_q      <= pkt_start_d;
      pkt_len_q        <= pkt_len_d;
      pkt_addr_err_q   <= pkt_addr_err_d;
      pkt_data_q       <= pkt_data_d;
      pkt_data_valid_q <= pkt_data_valid_d;
      pkt_end_q        <= pkt_end_d;
      pkt_err_q        <= pkt_err_d;
      abort_q          <= abort_d;
      pkt_count_q      <= pkt_count_d;
      err_count_q      <= err_count_d;
    end
  end

  // Read enable is held off while reset is asserted so the FIFO is never popped during reset
  assign re             = re_c & rst;
  assign busy           = (state_q != S_IDLE);
  assign pkt_start      = pkt_start_q;
  assign pkt_len        = pkt_len_q;
  assign pkt_addr_err   = pkt_addr_err_q;
  assign pkt_data       = pkt_data_q;
  assign pkt_data_valid = pkt_data_valid_q;
  assign pkt_end        = pkt_end_q;
  assign pkt_err        = pkt_err_q;
  assign abort          = abort_q;
  assign pkt_count      = pkt_count_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_pkt_receiver.sv
// Bench for pkt_receiver: a FIFO model feeds bytes with one-cycle read latency.
// Table of packets with hand-computed results, plus stall-abort and mid-packet reset sequences.
module tb_pkt_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in;
  logic [7:0]  data_in;
  logic        sink_ready;
  logic        re;
  logic        pkt_start;
  logic [5:0]  pkt_len;
  logic        pkt_addr_err;
  logic [7:0]  pkt_data;
  logic        pkt_data_valid;
  logic        pkt_end;
  logic        pkt_err;
  logic        abort;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;
  logic        busy;

  pkt_receiver #(.PORT_ID(2'd0), .WAIT_LIMIT(29)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .sink_ready(sink_ready),
    .re(re), .pkt_start(pkt_start), .pkt_len(pkt_len), .pkt_addr_err(pkt_addr_err),
    .pkt_data(pkt_data), .pkt_data_valid(pkt_data_valid), .pkt_end(pkt_end), .pkt_err(pkt_err),
    .abort(abort), .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] bytes;   // stream, first byte in the top octet
    logic [3:0]  nb;
    logic        toggle;  // sink_ready alternates every cycle
    logic [5:0]  len;
    logic        aerr;
    logic [31:0] dat;     // expected payload, first byte in the top octet
    logic [2:0]  nd;
    logic        err;
    logic [15:0] pc;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl [6];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] q [$];
  logic [7:0] nxt_byte;
  bit         have_nb;
  bit         sr_toggle;
  bit         sr_val;

  int         obs_start, obs_end, obs_abort, re_bad;
  logic [5:0] obs_len;
  logic       obs_aerr, obs_err;
  logic [7:0] obs_d [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_start = 0; obs_end = 0; obs_abort = 0; re_bad = 0;
    obs_len = '0; obs_aerr = 1'b0; obs_err = 1'b0;
    obs_d.delete();
  endtask

  // One cycle: drive inputs after the falling edge, observe 1ns later, model the FIFO pop
  task automatic tick();
    @(negedge clk);
    if (have_nb) begin
      data_in = nxt_byte;
      have_nb = 1'b0;
    end
    vld_in     = (q.size() != 0);
    sink_ready = sr_toggle ? cyc[0] : sr_val;
    #1;
    if (re && !sink_ready) re_bad++;
    if (pkt_start) begin
      obs_start++;
      obs_len  = pkt_len;
      obs_aerr = pkt_addr_err;
    end
    if (pkt_data_valid) obs_d.push_back(pkt_data);
    if (pkt_end) begin
      obs_end++;
      obs_err = pkt_err;
    end
    if (abort) obs_abort++;
    if (re) begin
      if (q.size() == 0) chk("read_from_empty_fifo", 32'd1, 32'd0);
      else begin
        nxt_byte = q.pop_front();
        have_nb  = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_re"}, re, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_pkt_start"}, pkt_start, 0);
    chk({pfx, "_pkt_data_valid"}, pkt_data_valid, 0);
    chk({pfx, "_pkt_end"}, pkt_end, 0);
    chk({pfx, "_pkt_err"}, pkt_err, 0);
    chk({pfx, "_abort"}, abort, 0);
    chk({pfx, "_pkt_addr_err"}, pkt_addr_err, 0);
    chk({pfx, "_pkt_data"}, pkt_data, 0);
    chk({pfx, "_pkt_len"}, pkt_len, 0);
    chk({pfx, "_pkt_count"}, pkt_count, 0);
    chk({pfx, "_err_count"}, err_count, 0);
  endtask

  task automatic run_pkt(input vec_t v, input int id);
    logic [7:0] got;
    clear_obs();
    sr_toggle = v.toggle;
    sr_val    = 1'b1;
    for (int j = 0; j < int'(v.nb); j++) q.push_back(v.bytes[63-8*j -: 8]);
    for (int k = 0; k < 300 && obs_end == 0 && obs_abort == 0; k++) tick();
    tick();
    tick();
    sr_toggle = 1'b0;
    chk($sformatf("v%0d_start_pulses", id), obs_start, 1);
    chk($sformatf("v%0d_len", id), obs_len, v.len);
    chk($sformatf("v%0d_addr_err", id), obs_aerr, v.aerr);
    chk($sformatf("v%0d_data_count", id), obs_d.size(), v.nd);
    for (int j = 0; j < int'(v.nd); j++) begin
      got = (obs_d.size() > j) ? obs_d[j] : 8'hxx;
      chk($sformatf("v%0d_data%0d", id, j), got, v.dat[31-8*j -: 8]);
    end
    chk($sformatf("v%0d_end_pulses", id), obs_end, 1);
    chk($sformatf("v%0d_pkt_err", id), obs_err, v.err);
    chk($sformatf("v%0d_abort", id), obs_abort, 0);
    chk($sformatf("v%0d_pkt_count", id), pkt_count, v.pc);
    chk($sformatf("v%0d_err_count", id), err_count, v.ec);
    chk($sformatf("v%0d_re_while_not_ready", id), re_bad, 0);
    chk($sformatf("v%0d_busy_after", id), busy, 0);
  endtask

  initial begin
    vec_t v;
    int   n;
    //        bytes                   nb    tgl   len   aerr  payload        nd    err   pkt    err_cnt
    tbl[0] = '{64'h0C11_2233_0C00_0000, 4'd5, 1'b0, 6'd3, 1'b0, 32'h1122_3300, 3'd3, 1'b0, 16'd1, 8'd0};
    tbl[1] = '{64'h0C11_2233_0D00_0000, 4'd5, 1'b0, 6'd3, 1'b0, 32'h1122_3300, 3'd3, 1'b1, 16'd1, 8'd1};
    tbl[2] = '{64'h0101_0000_0000_0000, 4'd2, 1'b0, 6'd0, 1'b1, 32'h0000_0000, 3'd0, 1'b0, 16'd1, 8'd2};
    tbl[3] = '{64'h10A1_B2C3_D414_0000, 4'd6, 1'b1, 6'd4, 1'b0, 32'hA1B2_C3D4, 3'd4, 1'b0, 16'd2, 8'd2};
    tbl[4] = '{64'h0000_0000_0000_0000, 4'd2, 1'b0, 6'd0, 1'b0, 32'h0000_0000, 3'd0, 1'b0, 16'd3, 8'd2};
    tbl[5] = '{64'h045A_5F00_0000_0000, 4'd3, 1'b0, 6'd1, 1'b0, 32'h5A00_0000, 3'd1, 1'b1, 16'd3, 8'd3};

    have_nb = 1'b0; sr_toggle = 1'b0; sr_val = 1'b1; nxt_byte = '0;
    clear_obs();

    // Reset state, with a would-be read request present
    rst = 1'b0; vld_in = 1'b1; sink_ready = 1'b1; data_in = 8'h00;
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    vld_in = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_pkt(tbl[i], i);

    // Stall in PAYLOAD: header read, then sink_ready held low with data pending
    clear_obs();
    for (int j = 0; j < 5; j++) q.push_back(tbl[0].bytes[63-8*j -: 8]);
    sr_val = 1'b1;
    tick();
    sr_val = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && obs_abort == 0; k++) begin
      tick();
      if (obs_abort == 0 && obs_start != 0) n++;
    end
    chk("abort_seen", obs_abort, 1);
    chk("abort_after_29_stall_cycles", n, 29);
    chk("abort_no_end", obs_end, 0);
    chk("abort_no_data", obs_d.size(), 0);
    chk("abort_err_count", err_count, 4);
    chk("abort_pkt_count", pkt_count, 3);
    sr_val = 1'b1;
    tick();
    chk("abort_one_cycle", abort, 0);
    chk("flush_busy", busy, 1);
    chk("flush_no_read", re, 0);
    q.delete();
    tick();
    tick();
    chk("flush_to_idle", busy, 0);

    // Reset after the second payload byte, then a clean packet
    clear_obs();
    sr_val = 1'b1;
    for (int j = 0; j < 5; j++) q.push_back(tbl[0].bytes[63-8*j -: 8]);
    for (int k = 0; k < 50 && obs_d.size() < 2; k++) tick();
    chk("midrst_two_bytes_seen", obs_d.size(), 2);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    have_nb = 1'b0;
    @(negedge clk);
    vld_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = tbl[0];
    v.pc = 16'd1;
    v.ec = 8'd0;
    run_pkt(v, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
